// File: rtl/sub_div_sequencer.sv
// Restoring unsigned divider controller that borrows one external N-bit subtractor
// for N iterations, producing one quotient bit per cycle behind a start/done handshake.
module sub_div_sequencer #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_zero_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic [N-1:0] sub_a_o,
  output logic [N-1:0] sub_b_o,
  input  logic [N-1:0] sub_result_i,
  input  logic         sub_cry_i
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic [N-1:0]   divisorReg_q, divisorReg_d;
  logic [CW-1:0]  counter_q, counter_d;
  logic           divZero_q, divZero_d;

  logic [N-1:0]   shifted;
  logic           outBit;
  logic           take;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      quotient_q   <= '0;
      remainder_q  <= '0;
      divisorReg_q <= '0;
      counter_q    <= '0;
      divZero_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      divisorReg_q <= divisorReg_d;
      counter_q    <= counter_d;
      divZero_q    <= divZero_d;
    end
  end

  // A set MSB shifted out of the remainder means the partial remainder is at least
  // 2^N, so the subtraction must succeed whatever the carry says.
  always_comb begin
    shifted      = {remainder_q[N-2:0], quotient_q[N-1]};
    outBit       = remainder_q[N-1];
    take         = outBit | sub_cry_i;

    state_d      = state_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    divisorReg_d = divisorReg_q;
    counter_d    = counter_q;
    divZero_d    = divZero_q;
    sub_a_o      = '0;
    sub_b_o      = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          quotient_d   = dividend_i;
          remainder_d  = '0;
          divisorReg_d = divisor_i;
          counter_d    = '0;
          divZero_d    = (divisor_i == '0);
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            state_d     = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        sub_a_o     = shifted;
        sub_b_o     = divisorReg_q;
        remainder_d = take ? sub_result_i : shifted;
        quotient_d  = {quotient_q[N-2:0], take};
        counter_d   = counter_q + 1'b1;
        if (counter_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q == ITER);
  assign done_o      = (state_q == DONE);
  assign div_zero_o  = divZero_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_sub_div_sequencer.sv
// Bench for sub_div_sequencer: models the external subtractor, applies a table of
// divides plus hand-written abort/ignore sequences and a random sweep, scoreboarding results.
module tb_sub_div_sequencer;

  localparam int N = 32;

  logic         clk_i;
  logic         rst_i;
  logic         start_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic         div_zero_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic [N-1:0] sub_a_o;
  logic [N-1:0] sub_b_o;
  logic [N-1:0] sub_result_i;
  logic         sub_cry_i;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  exp_t         sbQ[$];
  vec_t         vecs[10];
  logic [N-1:0] capturedDivisor;
  int           vectorCount;
  int           missCount;

  sub_div_sequencer #(.N(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_zero_o   (div_zero_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .sub_a_o      (sub_a_o),
    .sub_b_o      (sub_b_o),
    .sub_result_i (sub_result_i),
    .sub_cry_i    (sub_cry_i)
  );

  // External ripple subtractor: carry set means no borrow.
  assign sub_result_i = sub_a_o - sub_b_o;
  assign sub_cry_i    = (sub_a_o >= sub_b_o);

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic void checkOutput(string name, logic [N-1:0] act, logic [N-1:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard and operand monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (busy_o) begin
        checkOutput("sub_b_iter", sub_b_o, capturedDivisor);
      end else begin
        checkOutput("sub_a_quiet", sub_a_o, '0);
        checkOutput("sub_b_quiet", sub_b_o, '0);
      end
      if (done_o) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("quotient", quotient_o, e.q);
          checkOutput("remainder", remainder_o, e.r);
          checkOutput("div_zero", {31'd0, div_zero_o}, {31'd0, e.dz});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
    exp_t e;
    int cycles;
    int busyCnt;
    e.q = q; e.r = r; e.dz = dz;
    sbQ.push_back(e);
    capturedDivisor = b;
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    tick();
    start_i = 1'b0;
    cycles  = 0;
    busyCnt = 0;
    while (!done_o && cycles < N + 4) begin
      if (busy_o) busyCnt++;
      tick();
      cycles++;
    end
    checkOutput("done_timeout", {31'd0, done_o}, 32'd1);
    checkOutput("busy_cycles", busyCnt, (b == '0) ? 32'd0 : N);
    tick();
    checkOutput("done_pulse", {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    vectorCount = 0;
    missCount   = 0;
    capturedDivisor = '0;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    rst_i      = 1'b1;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0001,  q: 32'd1,          r: 32'h7FFF_FFFE,  dz: 1'b0};
    vecs[2] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          dz: 1'b0};
    vecs[3] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234,       dz: 1'b1};
    vecs[4] = '{a: 32'd50,         b: 32'd5,          q: 32'd10,         r: 32'd0,          dz: 1'b0};
    vecs[5] = '{a: 32'hDEAD_BEEF,  b: 32'd3,          q: 32'h4A39_EA4F,  r: 32'd2,          dz: 1'b0};
    vecs[6] = '{a: 32'd0,          b: 32'd1,          q: 32'd0,          r: 32'd0,          dz: 1'b0};
    vecs[7] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b0};
    vecs[8] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          dz: 1'b0};
    vecs[9] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dz: 1'b0};

    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_quotient", quotient_o, '0);
    checkOutput("rst_remainder", remainder_o, '0);
    checkOutput("rst_div_zero", {31'd0, div_zero_o}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Starts raised while busy and during DONE must be dropped.
    e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0;
    sbQ.push_back(e);
    capturedDivisor = 32'd7;
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < N + 4 && !done_o; c++) tick();
    checkOutput("ign_done_seen", {31'd0, done_o}, 32'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("ign_busy", {31'd0, busy_o}, 32'd0);
    tick();
    checkOutput("ign_busy2", {31'd0, busy_o}, 32'd0);
    checkOutput("ign_done2", {31'd0, done_o}, 32'd0);
    checkOutput("ign_hold_q", quotient_o, 32'd14);
    checkOutput("ign_hold_r", remainder_o, 32'd2);
    applyStimulus(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    // Reset mid-operation aborts with nothing reported.
    capturedDivisor = 32'd3;
    start_i = 1'b1; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'd3;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort_done", {31'd0, done_o}, 32'd0);
    checkOutput("abort_quotient", quotient_o, '0);
    checkOutput("abort_remainder", remainder_o, '0);
    checkOutput("abort_div_zero", {31'd0, div_zero_o}, 32'd0);
    applyStimulus(32'hDEAD_BEEF, 32'd3, 32'h4A39_EA4F, 32'd2, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 49) == 0) rb = '0;
      if (rb == '0)
        applyStimulus(ra, rb, '1, ra, 1'b1);
      else
        applyStimulus(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    tick();
    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
